// File: rtl/axi_slave_rd_arbiter.sv
// Per-slave read arbiter: round-robin grant of one AR among the masters, then
// routes the R beats of that single outstanding read back to the winner.
module axi_slave_rd_arbiter #(
  parameter int M_CNT  = 4,
  parameter int M_BITS = 2
) (
  input  logic                AXI_CLK_i,
  input  logic                AXI_RST_i,
  input  logic [M_CNT-1:0]    REQ_VALID_i,
  input  logic [M_CNT*49-1:0] REQ_DATA_i,
  output logic [M_CNT-1:0]    REQ_POP_o,
  output logic                S_ARVALID_o,
  output logic [48:0]         S_AR_DATA_o,
  input  logic                S_ARREADY_i,
  input  logic                S_RVALID_i,
  input  logic                S_RLAST_i,
  input  logic [7:0]          S_RID_i,
  output logic                S_RREADY_o,
  input  logic [M_CNT-1:0]    R_WFULL_i,
  output logic [M_CNT-1:0]    R_SEL_o,
  output logic                LEN_ERR_o,
  output logic                RID_ERR_o
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t            state, state_nxt;
  logic [M_BITS-1:0] rr_ptr, grant, win, idx;
  logic              win_found;
  logic [3:0]        beat_cnt;
  logic [48:0]       req_slice [M_CNT];
  logic              r_hs;

  function automatic logic [M_CNT-1:0] onehot(input logic [M_BITS-1:0] i);
    logic [M_CNT-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  for (genvar m = 0; m < M_CNT; m++) begin : g_slice
    assign req_slice[m] = REQ_DATA_i[m*49 +: 49];
  end

  // Scan upward from rr_ptr with wrap; first requester found wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < M_CNT; i++) begin
      idx = M_BITS'((int'(rr_ptr) + i) % M_CNT);
      if (!win_found && REQ_VALID_i[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  assign S_RREADY_o = (state == RESP) && !R_WFULL_i[grant];
  assign r_hs       = S_RVALID_i && S_RREADY_o;

  always_comb begin
    state_nxt   = state;
    REQ_POP_o   = '0;
    S_ARVALID_o = 1'b0;
    R_SEL_o     = '0;
    unique case (state)
      IDLE: begin
        // Pops are suppressed under reset so no AR is lost while the FSM is held.
        if (win_found && !AXI_RST_i) begin
          REQ_POP_o = onehot(win);
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        S_ARVALID_o = 1'b1;
        if (S_ARREADY_i) state_nxt = RESP;
      end
      RESP: begin
        if (r_hs) begin
          R_SEL_o = onehot(grant);
          if (S_RLAST_i) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (AXI_RST_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      beat_cnt    <= '0;
      S_AR_DATA_o <= '0;
      LEN_ERR_o   <= 1'b0;
      RID_ERR_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      LEN_ERR_o <= 1'b0;
      RID_ERR_o <= 1'b0;
      if (state == IDLE && win_found) begin
        S_AR_DATA_o <= req_slice[win];
        grant       <= win;
        beat_cnt    <= req_slice[win][8:5];
      end
      if (r_hs) begin
        if (beat_cnt != 4'd0) beat_cnt <= beat_cnt - 4'd1;
        RID_ERR_o <= (S_RID_i[7:4] != 4'(grant));
        // Counter reaches 0 exactly on the beat that should carry RLAST.
        LEN_ERR_o <= S_RLAST_i ? (beat_cnt != 4'd0) : (beat_cnt == 4'd0);
        if (S_RLAST_i)
          rr_ptr <= (grant == M_BITS'(M_CNT - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: doc/axi_slave_rd_arbiter.md
Name: axi_slave_rd_arbiter

Overview:
- Per-slave read-address arbiter and read-response router for the crossbar.
- Takes the AR requests that each master interface's address decoder marks for this slave and picks one with round-robin arbitration.
- Pops the winner's AR FIFO and drives the slave AR channel, then steers the R beats back to the winner's R-FIFO mux.
- Holds one outstanding read at a time per slave.

Parameters:
M_CNT, 4, number of master interfaces competing for this slave (2..6)
M_BITS, 2, width of master index, ceil(log2(M_CNT))

Ports:
AXI_CLK_i  input  1  crossbar clock
AXI_RST_i  input  1  reset, synchronous, active-high
REQ_VALID_i  input  M_CNT  bit m: master m AR FIFO non-empty and decoded to this slave
REQ_DATA_i  input  M_CNT*49  AR FIFO heads; slice m = {id[7:0], addr[31:0], len[3:0], size[2:0], burst[1:0]}
REQ_POP_o  output  M_CNT  one-hot pop to winning master's AR FIFO
S_ARVALID_o  output  1  slave AR valid
S_AR_DATA_o  output  49  latched AR payload, same layout
S_ARREADY_i  input  1  slave AR ready
S_RVALID_i  input  1  slave R valid
S_RLAST_i  input  1  slave R last
S_RID_i  input  8  slave R id; [7:4] = master number
S_RREADY_o  output  1  slave R ready
R_WFULL_i  input  M_CNT  per-master R FIFO full
R_SEL_o  output  M_CNT  one-hot R mux select / push for master R FIFO
LEN_ERR_o  output  1  one-cycle pulse: RLAST mismatched to ARLEN
RID_ERR_o  output  1  one-cycle pulse: RID[7:4] != granted master

Behaviour:
- One clock, AXI_CLK_i. Reset AXI_RST_i is synchronous and active-high.
- Reset values:
  - state=IDLE, rr pointer=0, grant index=0, beat counter=0
  - S_AR_DATA_o=0
  - all outputs 0
- States: IDLE, ADDR, RESP.
- IDLE, arbitration:
  - If REQ_VALID_i != 0, pick the first set bit scanning from rr pointer upward, wrapping M_CNT-1 -> 0.
  - Same cycle: REQ_POP_o = onehot(winner), a combinational one-cycle pulse.
  - Register S_AR_DATA_o <= winner's REQ_DATA_i slice, store grant index g, load beat counter with len = slice[8:5].
  - Next state ADDR.
  - No request: stay IDLE, REQ_POP_o=0.
- ADDR:
  - S_ARVALID_o=1; S_AR_DATA_o held stable.
  - On S_ARREADY_i=1, go to RESP the next cycle.
  - ARVALID must never drop before ready.
- RESP:
  - S_RREADY_o = ~R_WFULL_i[g].
  - R_SEL_o = onehot(g) only in a cycle where S_RVALID_i & S_RREADY_o; otherwise 0.
  - On each handshake:
    - Beat counter decrements, saturating at 0.
    - If S_RID_i[7:4] != g, RID_ERR_o pulses next cycle. The beat is still routed to g.
    - If S_RLAST_i=1: LEN_ERR_o pulses next cycle when counter != 0. Go to IDLE; rr pointer <= (g+1) mod M_CNT.
    - If counter==0 and S_RLAST_i=0: LEN_ERR_o pulses next cycle. Remain in RESP until RLAST.
- Latency:
  - Request to S_ARVALID_o: 1 cycle.
  - Last R handshake to next grant: 1 cycle (IDLE cycle), so back-to-back reads cost a minimum 1-cycle gap.
- Boundaries:
  - REQ_VALID_i for the winner may drop in ADDR/RESP; it is ignored because data is already latched.
  - R_WFULL_i[g] asserted mid-burst: S_RREADY_o=0, no R_SEL_o, counter holds.
  - Simultaneous RLAST handshake and new REQ_VALID_i: the request waits for IDLE.
  - Reset in any state: immediate return to IDLE with all outputs 0 next cycle. In-flight transaction abandoned, pointer reset to 0.
  - rr pointer updates only on completion, never on grant.

Test Plan:
- Only master 2 requests, ARLEN=3, ARREADY same cycle: REQ_POP_o=0100 for 1 cycle → ARVALID next cycle → 4 R beats, R_SEL_o=0100 each → IDLE, pointer=3, no errors.
- Masters 0 and 3 both request continuously with ARLEN=0: grants alternate 0,3,0,3. Each transaction is IDLE→ADDR→RESP, with exactly one pop per grant.
- S_ARREADY_i low for 5 cycles in ADDR: ARVALID stays 1, S_AR_DATA_o unchanged, no extra pop.
- R_WFULL_i[g]=1 for 3 cycles mid-burst (ARLEN=7): RREADY low those cycles, still exactly 8 R_SEL_o pulses, no LEN_ERR_o.
- ARLEN=3 but RLAST on beat 2 → LEN_ERR_o pulse, IDLE. RID[7:4]=1 while g=0 → RID_ERR_o pulse, beat routed to master 0.
- Assert AXI_RST_i during RESP: next cycle all outputs 0 and state IDLE. A pending request is granted from pointer 0 after reset releases.
